// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel synchronizer, debouncer and edge detector
//
// Purpose:
//   Conditions a bus of asynchronous board-level inputs for synchronous logic.
//   Each channel is synchronized through a sync_stages-deep flop chain, then
//   (optionally) debounced against a shared sample tick, then edge-detected.
//
// Ports:
//   clk          in   system clock, rising-edge active
//   rst_n        in   asynchronous active-low reset
//   async_signal in   [width] raw asynchronous inputs
//   sync_signal  out  [width] last stage of each synchronizer chain
//   clean_signal out  [width] debounced level (sync_signal when debounce_en=0)
//   rise_pulse   out  [width] one-cycle pulse on 0->1 of clean_signal
//   fall_pulse   out  [width] one-cycle pulse on 1->0 of clean_signal

module input_conditioner #(
  parameter int width            = 1,
  parameter int sync_stages      = 2,
  parameter int debounce_en      = 1,
  parameter int sample_count_max = 25000,
  parameter int pulse_count_max  = 150
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] async_signal,
  output logic [width-1:0] sync_signal,
  output logic [width-1:0] clean_signal,
  output logic [width-1:0] rise_pulse,
  output logic [width-1:0] fall_pulse
);

  if (sync_stages < 2) begin : g_bad_sync_stages
    $error("input_conditioner: sync_stages must be >= 2");
  end
  if (sample_count_max < 1) begin : g_bad_sample_count
    $error("input_conditioner: sample_count_max must be >= 1");
  end
  if (pulse_count_max < 1) begin : g_bad_pulse_count
    $error("input_conditioner: pulse_count_max must be >= 1");
  end

  // Synchronizer chains: stage 0 captures the raw input, the last stage is
  // the first value safe to use in the clk domain.
  logic [width-1:0] sync_q [sync_stages];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < sync_stages; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= async_signal;
      for (int s = 1; s < sync_stages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_signal = sync_q[sync_stages-1];

  logic [width-1:0] clean;

  if (debounce_en != 0) begin : g_debounce
    localparam int tick_w = (sample_count_max > 1) ? $clog2(sample_count_max) : 1;
    localparam int cnt_w  = $clog2(pulse_count_max + 1);
    localparam logic [tick_w-1:0] tick_last  = tick_w'(sample_count_max - 1);
    localparam logic [cnt_w-1:0]  cnt_accept = cnt_w'(pulse_count_max);

    logic [tick_w-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [cnt_w-1:0]  cnt_q [width];
    logic [cnt_w-1:0]  cnt_d [width];
    logic [width-1:0]  clean_q, clean_d;

    // Shared sample tick; with sample_count_max=1 tick_last is 0 and the
    // counter sits at 0, so tick is asserted every cycle.
    assign tick       = (tick_cnt_q == tick_last);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + tick_w'(1);

    always_comb begin
      clean_d = clean_q;
      for (int i = 0; i < width; i++) begin
        // Any cycle of agreement throws away accumulated disagreement.
        cnt_d[i] = '0;
        if (sync_signal[i] != clean_q[i]) begin
          cnt_d[i] = cnt_q[i];
          if (tick) begin
            // cnt_q never exceeds pulse_count_max-1, so the increment
            // cannot overflow cnt_w bits.
            if (cnt_q[i] + cnt_w'(1) == cnt_accept) begin
              clean_d[i] = sync_signal[i];
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + cnt_w'(1);
            end
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tick_cnt_q <= '0;
        clean_q    <= '0;
        for (int i = 0; i < width; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        tick_cnt_q <= tick_cnt_d;
        clean_q    <= clean_d;
        for (int i = 0; i < width; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign clean = clean_q;
  end else begin : g_bypass
    assign clean = sync_signal;
  end

  // Edge detection against the previous cycle's clean level.
  logic [width-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= clean;
    end
  end

  assign clean_signal = clean;
  assign rise_pulse   = clean & ~prev_q;
  assign fall_pulse   = ~clean & prev_q;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised, multi-channel successor to the 2-flop synchronizer. Each channel of an asynchronous input bus passes through a configurable-depth synchronizer chain, then an optional sample-tick-based debouncer, then rising and falling edge detectors. The block sits between board I/O (buttons, switches, external strobes) and synchronous FSM logic. It replaces ad-hoc synchronizer, debouncer and edge-detector chains.

Parameters:
width, 1, number of independent channels
sync_stages, 2, flip-flops per synchronizer chain; must be >= 2 (elaboration error otherwise)
debounce_en, 1, 1 = debouncer present; 0 = debouncer bypassed
sample_count_max, 25000, sample-tick period in clk cycles; must be >= 1
pulse_count_max, 150, consecutive disagreeing ticks needed to accept a new level; must be >= 1

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
async_signal  input  width  raw asynchronous inputs
sync_signal  output  width  synchronizer-chain outputs (last stage)
clean_signal  output  width  debounced level (equal to sync_signal when debounce_en=0)
rise_pulse  output  width  one-cycle pulse on each 0->1 transition of clean_signal
fall_pulse  output  width  one-cycle pulse on each 1->0 transition of clean_signal

Behaviour:
- Reset: rst_n low forces all sync flops, the tick counter, channel counters, clean_signal and the edge-history register to 0 immediately, with no clock needed. All outputs are 0 while reset is held.
- Synchronizer: per bit, a shift chain of sync_stages flops. A level present at async_signal before edge n appears on sync_signal after edge n+sync_stages-1. With sync_stages=2, an input that rises between edges k-1 and k is visible after edge k+1.
- Sample tick: a free-running counter counts 0..sample_count_max-1 and wraps. tick=1 for exactly the one cycle when the counter equals sample_count_max-1. With sample_count_max=1, tick=1 every cycle. The counter is shared by all channels.
- Per-channel counter: width is clog2(pulse_count_max+1).
  - If sync_signal[i]==clean_signal[i], cnt[i] clears to 0 on the next edge.
  - Otherwise, on edges where tick=1, cnt[i] increments.
  - If the incremented value equals pulse_count_max, clean_signal[i] takes the value of sync_signal[i] and cnt[i] clears on that same edge.
  - A single cycle of agreement discards all accumulated count.
  - The counter never exceeds pulse_count_max.
- Acceptance latency: clean_signal changes between (pulse_count_max-1)*sample_count_max+1 and pulse_count_max*sample_count_max cycles after sync_signal settles, depending on tick phase.
- debounce_en=0: clean_signal is sync_signal combinationally. No tick counter or channel counters are generated.
- Edge detect: prev[i] registers clean_signal[i] each cycle. rise_pulse[i] = clean[i] & ~prev[i]; fall_pulse[i] = ~clean[i] & prev[i]. Each pulse is high only during the first cycle of the new level. rise and fall are never both high on one channel.
- Channels are fully independent; simultaneous changes on several channels produce simultaneous pulses.
- Input held 1 through reset release: clean rises after normal debounce and exactly one rise_pulse is emitted. This is the intended behaviour.
- Reset mid-count: all progress is lost; counting restarts from 0 after release, with the tick phase also restarting at 0.

Test Plan:
1. Latency (width=1, sync_stages=3, debounce_en=0): raise async at t=2 ns after an edge -> sync_signal 0 after edges 1–2, 1 after edge 3. clean_signal and rise_pulse are high for exactly the cycle after edge 3.
2. Debounce accept (width=2, sync_stages=2, sample_count_max=4, pulse_count_max=3): hold async[0]=1 -> clean_signal[0] rises 9–12 cycles after sync_signal[0]. rise_pulse[0] is high for exactly 1 cycle. Channel 1 stays 0 with no pulses.
3. Bounce reject (same params): while clean[0]=0, pulse async[0] high for 1 cycle every 6 cycles for 60 cycles -> clean_signal[0] stays 0 and no rise_pulse occurs. Then hold async[0]=1 -> acceptance occurs within the case-2 window.
4. Release (same params): from clean[0]=1, drop async[0] to 0 and hold -> fall_pulse[0] fires once, and clean[0]=0 in the same cycle. Simultaneously toggle async[1] 0->1 -> channel 1 gets an independent rise_pulse.
5. Async reset mid-operation: drop rst_n for 3 ns between edges while cnt[0]=2 -> all outputs 0 before the next edge. Release with async[0]=1 -> full debounce latency is measured again, with exactly one rise_pulse.
6. Wide bus (width=8, sample_count_max=1, pulse_count_max=1): drive async=8'hA5 then 8'h5A -> after acceptance, rise_pulse=8'hA5. Next transition gives rise_pulse=8'h5A and fall_pulse=8'hA5 in the same cycle.
